// File: rtl/mccpu_mem_responder.sv
// rtl/mccpu_mem_responder.sv - Unified word memory with req/ack handshake and wait states for the multicycle MIPS CPU
module mccpu_mem_responder #(
    parameter int ADDR_W      = 10,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [3:0]  be,
    output logic [31:0] rdata,
    output logic        ack,
    output logic        err,
    output logic        busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    localparam int          DEPTH    = 2 ** ADDR_W;
    localparam logic [3:0]  CNT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;
    localparam logic        NO_WAIT  = (WAIT_CYCLES == 0);

    // Word storage; intentionally not reset so the bench can preload it.
    logic [31:0] mem [0:DEPTH-1];

    state_t              r_state;
    logic [3:0]          r_cnt;
    logic                r_live;
    logic [ADDR_W+1:0]   r_addr;
    logic                r_we;
    logic [31:0]         r_wdata;
    logic [3:0]          r_be;
    logic [31:0]         r_rdata;
    logic                r_ack;
    logic                r_err;
    logic                r_busy;

    state_t              w_next_state;
    logic [3:0]          w_cnt_next;
    logic                w_capture;
    logic                w_commit;
    logic                w_from_inputs;
    logic [ADDR_W+1:0]   w_addr;
    logic                w_we;
    logic [31:0]         w_wdata;
    logic [3:0]          w_be;
    logic [ADDR_W-1:0]   w_word_idx;
    logic                w_misaligned;
    logic [31:0]         w_rd_word;
    logic [31:0]         w_wr_word;
    logic                w_unused;

    // Upper address bits are don't-care: accesses wrap modulo the memory depth.
    assign w_unused = ^addr[31:ADDR_W+2];

    // Next-state and wait-counter logic.
    always_comb begin
        w_next_state = r_state;
        w_cnt_next   = r_cnt;
        w_capture    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (req && r_live) begin
                    w_capture = 1'b1;
                    if (NO_WAIT) begin
                        w_next_state = S_RESP;
                    end else begin
                        w_next_state = S_WAIT;
                        w_cnt_next   = CNT_LOAD;
                    end
                end
            end
            S_WAIT: begin
                if (r_cnt == 4'd0) begin
                    w_next_state = S_RESP;
                end else begin
                    w_cnt_next = r_cnt - 4'd1;
                end
            end
            S_RESP: begin
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // Effects land on the edge entering RESP. With zero wait states that is the
    // capture edge itself, so the live inputs are used instead of the latched copy.
    assign w_commit      = (w_next_state == S_RESP);
    assign w_from_inputs = (r_state == S_IDLE);
    assign w_addr        = w_from_inputs ? addr[ADDR_W+1:0] : r_addr;
    assign w_we          = w_from_inputs ? we    : r_we;
    assign w_wdata       = w_from_inputs ? wdata : r_wdata;
    assign w_be          = w_from_inputs ? be    : r_be;
    assign w_word_idx    = w_addr[ADDR_W+1:2];
    assign w_misaligned  = (w_addr[1:0] != 2'b00);
    assign w_rd_word     = mem[w_word_idx];

    // Byte-lane merge of store data over the current word.
    always_comb begin
        w_wr_word = w_rd_word;
        for (int i = 0; i < 4; i++) begin
            if (w_be[i]) begin
                w_wr_word[8*i +: 8] = w_wdata[8*i +: 8];
            end
        end
    end

    // Memory write port. r_live holds off capture until the first edge after
    // reset release, so nothing can be committed while rst is asserted.
    always_ff @(posedge clk) begin
        if (w_commit && w_we && !w_misaligned) begin
            mem[w_word_idx] <= w_wr_word;
        end
    end

    // Request latch: the transaction keeps its own copy of the inputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr  <= '0;
            r_we    <= 1'b0;
            r_wdata <= '0;
            r_be    <= '0;
        end else if (w_capture) begin
            r_addr  <= addr[ADDR_W+1:0];
            r_we    <= we;
            r_wdata <= wdata;
            r_be    <= be;
        end
    end

    // State register, counter and registered response outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
            r_live  <= 1'b0;
            r_rdata <= '0;
            r_ack   <= 1'b0;
            r_err   <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_live  <= 1'b1;
            r_state <= w_next_state;
            r_cnt   <= w_cnt_next;
            r_ack   <= w_commit;
            r_busy  <= (w_next_state != S_IDLE);
            if (w_commit) begin
                r_err <= w_misaligned;
                if (!w_we && !w_misaligned) begin
                    r_rdata <= w_rd_word;
                end
            end
        end
    end

    assign rdata = r_rdata;
    assign ack   = r_ack;
    assign err   = r_err;
    assign busy  = r_busy;

endmodule

// File: tb/tb_mccpu_mem_responder.sv
// tb/tb_mccpu_mem_responder.sv - Scoreboard bench for mccpu_mem_responder (2 and 0 wait states)
module tb_mccpu_mem_responder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        req2 = 1'b0, we2 = 1'b0;
    logic [31:0] addr2 = '0, wdata2 = '0;
    logic [3:0]  be2 = '0;
    logic [31:0] rdata2;
    logic        ack2, err2, busy2;

    logic        req0 = 1'b0, we0 = 1'b0;
    logic [31:0] addr0 = '0, wdata0 = '0;
    logic [3:0]  be0 = '0;
    logic [31:0] rdata0;
    logic        ack0, err0, busy0;

    int total = 0;
    int bad   = 0;

    logic [32:0] q2[$];
    logic [32:0] q0[$];
    logic [32:0] e2, e0;

    always #5 clk = ~clk;

    mccpu_mem_responder #(.ADDR_W(10), .WAIT_CYCLES(2)) u_dut2 (
        .clk(clk), .rst(rst), .req(req2), .we(we2), .addr(addr2), .wdata(wdata2),
        .be(be2), .rdata(rdata2), .ack(ack2), .err(err2), .busy(busy2)
    );

    mccpu_mem_responder #(.ADDR_W(10), .WAIT_CYCLES(0)) u_dut0 (
        .clk(clk), .rst(rst), .req(req0), .we(we0), .addr(addr0), .wdata(wdata0),
        .be(be0), .rdata(rdata0), .ack(ack0), .err(err0), .busy(busy0)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Monitors: pop the expected response whenever a DUT acks.
    always @(negedge clk) begin
        if (ack2) begin
            if (q2.size() == 0) begin
                total++; bad++;
                $display("FAIL dut2_unexpected_ack: got ack rdata=%h expected no ack", rdata2);
            end else begin
                e2 = q2.pop_front();
                chk("dut2_rdata", rdata2, e2[32:1]);
                chk("dut2_err", {31'b0, err2}, {31'b0, e2[0]});
            end
        end
    end

    always @(negedge clk) begin
        if (ack0) begin
            if (q0.size() == 0) begin
                total++; bad++;
                $display("FAIL dut0_unexpected_ack: got ack rdata=%h expected no ack", rdata0);
            end else begin
                e0 = q0.pop_front();
                chk("dut0_rdata", rdata0, e0[32:1]);
                chk("dut0_err", {31'b0, err0}, {31'b0, e0[0]});
            end
        end
    end

    // One transaction on the 2-wait-state DUT; inputs are scrambled right after capture.
    task automatic txn2(input string nm, input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] b, input logic [31:0] er, input logic ee);
        int n;
        @(negedge clk);
        req2 = 1'b1; we2 = w; addr2 = a; wdata2 = d; be2 = b;
        q2.push_back({er, ee});
        @(posedge clk);
        @(negedge clk);
        req2 = 1'b0; we2 = ~w; addr2 = $urandom; wdata2 = $urandom; be2 = 4'($urandom);
        chk({nm, "_busy_wait"}, {31'b0, busy2}, 32'd1);
        n = 0;
        while (!ack2 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({nm, "_latency"}, n, 32'd2);
        chk({nm, "_busy_resp"}, {31'b0, busy2}, 32'd1);
        @(negedge clk);
        chk({nm, "_ack_drop"}, {31'b0, ack2}, 32'd0);
        chk({nm, "_busy_idle"}, {31'b0, busy2}, 32'd0);
    endtask

    // One transaction on the 0-wait-state DUT with req held high across calls.
    task automatic step0(input logic w, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] b, input logic [31:0] er, input logic ee);
        req0 = 1'b1; we0 = w; addr0 = a; wdata0 = d; be0 = b;
        q0.push_back({er, ee});
        @(negedge clk);
        chk("dut0_ack_hi", {31'b0, ack0}, 32'd1);
        @(negedge clk);
        chk("dut0_ack_lo", {31'b0, ack0}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        u_dut2.mem[0] = 32'h0BAD_F00D;
        u_dut2.mem[1] = 32'hCAFE_BABE;
        u_dut2.mem[2] = 32'hFFFF_FFFF;
        u_dut2.mem[3] = 32'h0000_0000;
        u_dut2.mem[4] = 32'h1234_5678;
        u_dut0.mem[0] = 32'hDEAD_BEEF;
        u_dut0.mem[1] = 32'h0102_0304;
        u_dut0.mem[5] = 32'h0000_0055;
        u_dut0.mem[1023] = 32'h0000_0077;

        repeat (2) @(posedge clk);
        #1;
        chk("reset_rdata", rdata2, 32'd0);
        chk("reset_ack", {31'b0, ack2}, 32'd0);
        chk("reset_err", {31'b0, err2}, 32'd0);
        chk("reset_busy", {31'b0, busy2}, 32'd0);
        chk("reset_rdata0", rdata0, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        txn2("ld_aligned", 1'b0, 32'h10, 32'h0, 4'h0, 32'h1234_5678, 1'b0);
        txn2("st_partial", 1'b1, 32'h8, 32'hAABB_CCDD, 4'b0101, 32'h1234_5678, 1'b0);
        txn2("ld_partial", 1'b0, 32'h8, 32'h0, 4'h0, 32'hFFBB_FFDD, 1'b0);
        txn2("st_misal", 1'b1, 32'h6, 32'h5555_5555, 4'hF, 32'hFFBB_FFDD, 1'b1);
        chk("misal_mem1", u_dut2.mem[1], 32'hCAFE_BABE);
        txn2("st_be0", 1'b1, 32'h4, 32'h1212_1212, 4'h0, 32'hFFBB_FFDD, 1'b0);
        chk("be0_mem1", u_dut2.mem[1], 32'hCAFE_BABE);
        txn2("ld_misal", 1'b0, 32'h3, 32'h0, 4'h0, 32'hFFBB_FFDD, 1'b1);
        txn2("st_capture", 1'b1, 32'hC, 32'h1122_3344, 4'hF, 32'hFFBB_FFDD, 1'b0);
        txn2("ld_capture", 1'b0, 32'hC, 32'h0, 4'h0, 32'h1122_3344, 1'b0);
        txn2("ld_wrap", 1'b0, 32'h1010, 32'h0, 4'h0, 32'h1234_5678, 1'b0);

        // Reset while a store to word 0 sits in WAIT.
        @(negedge clk);
        req2 = 1'b1; we2 = 1'b1; addr2 = 32'h0; wdata2 = 32'hFFFF_FFFF; be2 = 4'hF;
        @(posedge clk);
        @(negedge clk);
        req2 = 1'b0;
        chk("abort_busy_before", {31'b0, busy2}, 32'd1);
        rst = 1'b1;
        #1;
        chk("abort_rdata", rdata2, 32'd0);
        chk("abort_ack", {31'b0, ack2}, 32'd0);
        chk("abort_err", {31'b0, err2}, 32'd0);
        chk("abort_busy", {31'b0, busy2}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        chk("abort_mem0", u_dut2.mem[0], 32'h0BAD_F00D);
        txn2("ld_after_rst", 1'b0, 32'h0, 32'h0, 4'h0, 32'h0BAD_F00D, 1'b0);
        txn2("st_raw", 1'b1, 32'h4, 32'h600D_CAFE, 4'hF, 32'h0BAD_F00D, 1'b0);
        txn2("ld_raw", 1'b0, 32'h4, 32'h0, 4'h0, 32'h600D_CAFE, 1'b0);

        // Zero wait states, req held high: one ack every second cycle.
        @(negedge clk);
        step0(1'b0, 32'h1000, 32'h0, 4'h0, 32'hDEAD_BEEF, 1'b0);
        step0(1'b0, 32'h4, 32'h0, 4'h0, 32'h0102_0304, 1'b0);
        step0(1'b1, 32'h14, 32'hA0B0_C0D0, 4'b1000, 32'h0102_0304, 1'b0);
        step0(1'b0, 32'h1014, 32'h0, 4'h0, 32'hA000_0055, 1'b0);
        step0(1'b0, 32'hFFC, 32'h0, 4'h0, 32'h0000_0077, 1'b0);
        step0(1'b0, 32'h2, 32'h0, 4'h0, 32'h0000_0077, 1'b1);
        req0 = 1'b0;
        repeat (4) @(negedge clk);

        chk("q2_drained", q2.size(), 32'd0);
        chk("q0_drained", q0.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mccpu_mem_responder.md
Name: mccpu_mem_responder

Overview:
- Memory-side responder for the multicycle MIPS CPU. Serves instruction fetch and data load/store requests from a single unified word memory.
- Replaces the zero-latency memory model with a req/ack handshake and a configurable number of wait states.
- Supports byte-enabled stores and flags misaligned accesses, so the CPU FSM can be exercised against realistic memory timing.

Parameters:
- ADDR_W, 10, word-address bits; memory depth = 2**ADDR_W words of 32 bits.
- WAIT_CYCLES, 2, wait states between request capture and response (0..15).

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- req  input  1  request strobe from CPU; sampled only in IDLE.
- we  input  1  1 = store, 0 = load/fetch.
- addr  input  32  byte address.
- wdata  input  32  store data.
- be  input  4  byte enables for stores; be[i] covers wdata[8i+7:8i].
- rdata  output  32  read data, valid while ack=1, held afterwards.
- ack  output  1  one-cycle completion pulse.
- err  output  1  misalignment flag, valid while ack=1.
- busy  output  1  high in WAIT and RESP.

Behaviour:
- All outputs are registered. Clock and reset are as decided: reset rst, asynchronous, active-high; clock clk.
- Reset: state=IDLE, wait counter=0, rdata=0, ack=0, err=0, busy=0. Memory array is not reset.
- A reset asserted mid-transaction aborts the transaction: no write is committed and no ack is issued.
- States and transitions:
  - IDLE: when req=1 at a rising edge, latch addr, we, wdata and be. If WAIT_CYCLES=0, go to RESP; otherwise load counter=WAIT_CYCLES-1 and go to WAIT. When req=0, stay in IDLE.
  - WAIT: while counter≠0, decrement it. When counter=0, go to RESP. req is ignored.
  - RESP: ack=1 for exactly one cycle, then go to IDLE.
- Effects are committed on the edge that enters RESP:
  - Aligned load: rdata ← mem[addr[ADDR_W+1:2]].
  - Aligned store: each byte lane with be[i]=1 is written. Lanes with be=0 are unchanged. rdata is unchanged.
  - Misaligned access (addr[1:0]≠0): err=1, no write, rdata unchanged.
  - Aligned access: err=0.
- Latency: a request sampled at edge t produces ack high during cycle t+WAIT_CYCLES+1. It is therefore visible at edge t+WAIT_CYCLES+1 and low again by edge t+WAIT_CYCLES+2.
- Back-to-back requests: req is not sampled in RESP. If req is still high in the following IDLE cycle, it is captured as a new request, giving a minimum of WAIT_CYCLES+2 cycles per transaction.
- Address range: addr[31:ADDR_W+2] is ignored, so addresses wrap modulo the memory depth.
- A store with be=4'b0000 completes normally (ack=1, err=0) with no memory change.
- Inputs addr, we, wdata and be may change after capture without affecting the transaction in progress.
- Memory contents may be preloaded by the bench via hierarchical access to the array `mem`.
- Read-after-write: a load issued after a store's ack returns the updated word.

Test Plan:
- Aligned load (WAIT_CYCLES=2): mem[4]=32'h1234_5678; req at edge 0 with addr=32'h10, we=0 → ack=1 only at edge 3; rdata=32'h1234_5678; err=0; busy high during edges 1–3.
- Partial store then load: mem[2]=32'hFFFF_FFFF; store addr=32'h8, wdata=32'hAABB_CCDD, be=4'b0101 → load addr=32'h8 returns 32'hFFBB_FFDD.
- Misaligned store: addr=32'h6, we=1, be=4'hF → ack with err=1; mem[1] unchanged; rdata retains its previous value.
- Zero wait states (WAIT_CYCLES=0) with req held high → ack on every 2nd cycle; addresses wrap, e.g. addr=32'h1000 reads mem[0] when ADDR_W=10.
- Reset during WAIT of a store to addr=0 → ack never asserted; mem[0] unchanged; all outputs 0 after reset; a subsequent request completes normally.
- Input change after capture: modify addr/wdata during WAIT → the originally captured values are used.
